// File: rtl/decode_stage.sv
// MIPS instruction-decode stage: register file with writeback bypass, control
// decode, immediate sign extension, load-use hazard detection and ID/EX register.
module decode_stage #(
    parameter int REG_COUNT = 32,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       instruction_if_id,
    input  logic [DATA_W-1:0] next_address_if_id,
    input  logic              flush,
    input  logic              ctrl_regWrite_wb,
    input  logic [4:0]        write_register_wb,
    input  logic [DATA_W-1:0] write_data_wb,
    output logic              hazard_stall,
    output logic [DATA_W-1:0] read_data_1_id_ex,
    output logic [DATA_W-1:0] read_data_2_id_ex,
    output logic [DATA_W-1:0] extended_branch_offset_id_ex,
    output logic [DATA_W-1:0] supposed_next_address_id_ex,
    output logic [4:0]        next_instruction_20_16_id_ex,
    output logic [4:0]        next_instruction_15_11_id_ex,
    output logic [1:0]        ctrl_aluOp_id_ex,
    output logic              ctrl_aluSrc_id_ex,
    output logic              ctrl_regDest_id_ex,
    output logic              ctrl_memRead_id_ex,
    output logic              ctrl_memWrite_id_ex,
    output logic              ctrl_memToReg_id_ex,
    output logic              ctrl_regWrite_id_ex,
    output logic              ctrl_branch_id_ex,
    output logic              illegal_opcode_id_ex
);

    typedef enum logic [5:0] {
        OP_RTYPE = 6'b000000,
        OP_LW    = 6'b100011,
        OP_SW    = 6'b101011,
        OP_BEQ   = 6'b000100,
        OP_ADDI  = 6'b001000
    } opcode_e;

    logic [DATA_W-1:0] r_regs [REG_COUNT];

    logic [5:0]        w_opcode;
    logic [4:0]        w_rs;
    logic [4:0]        w_rt;
    logic [4:0]        w_rd;
    logic              w_wbActive;
    logic [DATA_W-1:0] w_readData1;
    logic [DATA_W-1:0] w_readData2;
    logic [DATA_W-1:0] w_extImm;

    logic [1:0]        w_aluOp;
    logic              w_aluSrc;
    logic              w_regDest;
    logic              w_memRead;
    logic              w_memWrite;
    logic              w_memToReg;
    logic              w_regWrite;
    logic              w_branch;
    logic              w_illegal;
    logic              w_bubble;

    assign w_opcode   = instruction_if_id[31:26];
    assign w_rs       = instruction_if_id[25:21];
    assign w_rt       = instruction_if_id[20:16];
    assign w_rd       = instruction_if_id[15:11];
    assign w_extImm   = {{(DATA_W-16){instruction_if_id[15]}}, instruction_if_id[15:0]};
    assign w_wbActive = ctrl_regWrite_wb && (write_register_wb != 5'd0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wbActive) begin
            r_regs[write_register_wb] <= write_data_wb;
        end
    end

    // Writeback data is forwarded so a same-cycle write is visible to decode.
    always_comb begin
        w_readData1 = '0;
        w_readData2 = '0;
        if (w_rs != 5'd0) begin
            w_readData1 = (w_wbActive && write_register_wb == w_rs) ? write_data_wb : r_regs[w_rs];
        end
        if (w_rt != 5'd0) begin
            w_readData2 = (w_wbActive && write_register_wb == w_rt) ? write_data_wb : r_regs[w_rt];
        end
    end

    always_comb begin
        w_aluOp    = 2'b00;
        w_aluSrc   = 1'b0;
        w_regDest  = 1'b0;
        w_memRead  = 1'b0;
        w_memWrite = 1'b0;
        w_memToReg = 1'b0;
        w_regWrite = 1'b0;
        w_branch   = 1'b0;
        w_illegal  = 1'b0;
        case (w_opcode)
            OP_RTYPE: begin
                w_regDest  = 1'b1;
                w_aluOp    = 2'b10;
                w_regWrite = 1'b1;
            end
            OP_LW: begin
                w_aluSrc   = 1'b1;
                w_memRead  = 1'b1;
                w_memToReg = 1'b1;
                w_regWrite = 1'b1;
            end
            OP_SW: begin
                w_aluSrc   = 1'b1;
                w_memWrite = 1'b1;
            end
            OP_BEQ: begin
                w_branch   = 1'b1;
                w_aluOp    = 2'b01;
            end
            OP_ADDI: begin
                w_aluSrc   = 1'b1;
                w_regWrite = 1'b1;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // rs and rt are both compared regardless of opcode, so stalls are conservative.
    assign hazard_stall = ctrl_memRead_id_ex
                       && (next_instruction_20_16_id_ex == w_rs || next_instruction_20_16_id_ex == w_rt)
                       && (next_instruction_20_16_id_ex != 5'd0);
    assign w_bubble = flush || hazard_stall;

    always_ff @(posedge clk) begin
        if (!reset) begin
            read_data_1_id_ex            <= '0;
            read_data_2_id_ex            <= '0;
            extended_branch_offset_id_ex <= '0;
            supposed_next_address_id_ex  <= '0;
            next_instruction_20_16_id_ex <= '0;
            next_instruction_15_11_id_ex <= '0;
            ctrl_aluOp_id_ex             <= '0;
            ctrl_aluSrc_id_ex            <= 1'b0;
            ctrl_regDest_id_ex           <= 1'b0;
            ctrl_memRead_id_ex           <= 1'b0;
            ctrl_memWrite_id_ex          <= 1'b0;
            ctrl_memToReg_id_ex          <= 1'b0;
            ctrl_regWrite_id_ex          <= 1'b0;
            ctrl_branch_id_ex            <= 1'b0;
            illegal_opcode_id_ex         <= 1'b0;
        end else begin
            read_data_1_id_ex            <= w_readData1;
            read_data_2_id_ex            <= w_readData2;
            extended_branch_offset_id_ex <= w_extImm;
            supposed_next_address_id_ex  <= next_address_if_id;
            next_instruction_20_16_id_ex <= w_rt;
            next_instruction_15_11_id_ex <= w_rd;
            // A bubble keeps the data fields but kills every control bit.
            ctrl_aluOp_id_ex             <= w_bubble ? 2'b00 : w_aluOp;
            ctrl_aluSrc_id_ex            <= w_aluSrc   && !w_bubble;
            ctrl_regDest_id_ex           <= w_regDest  && !w_bubble;
            ctrl_memRead_id_ex           <= w_memRead  && !w_bubble;
            ctrl_memWrite_id_ex          <= w_memWrite && !w_bubble;
            ctrl_memToReg_id_ex          <= w_memToReg && !w_bubble;
            ctrl_regWrite_id_ex          <= w_regWrite && !w_bubble;
            ctrl_branch_id_ex            <= w_branch   && !w_bubble;
            illegal_opcode_id_ex         <= w_illegal  && !w_bubble;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed MIPS sequences plus random traffic
// checked against a behavioural model of the decode rules.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction_if_id;
    logic [31:0] next_address_if_id;
    logic        flush;
    logic        ctrl_regWrite_wb;
    logic [4:0]  write_register_wb;
    logic [31:0] write_data_wb;
    logic        hazard_stall;
    logic [31:0] read_data_1_id_ex;
    logic [31:0] read_data_2_id_ex;
    logic [31:0] extended_branch_offset_id_ex;
    logic [31:0] supposed_next_address_id_ex;
    logic [4:0]  next_instruction_20_16_id_ex;
    logic [4:0]  next_instruction_15_11_id_ex;
    logic [1:0]  ctrl_aluOp_id_ex;
    logic        ctrl_aluSrc_id_ex;
    logic        ctrl_regDest_id_ex;
    logic        ctrl_memRead_id_ex;
    logic        ctrl_memWrite_id_ex;
    logic        ctrl_memToReg_id_ex;
    logic        ctrl_regWrite_id_ex;
    logic        ctrl_branch_id_ex;
    logic        illegal_opcode_id_ex;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk                          (clk),
        .reset                        (reset),
        .instruction_if_id            (instruction_if_id),
        .next_address_if_id           (next_address_if_id),
        .flush                        (flush),
        .ctrl_regWrite_wb             (ctrl_regWrite_wb),
        .write_register_wb            (write_register_wb),
        .write_data_wb                (write_data_wb),
        .hazard_stall                 (hazard_stall),
        .read_data_1_id_ex            (read_data_1_id_ex),
        .read_data_2_id_ex            (read_data_2_id_ex),
        .extended_branch_offset_id_ex (extended_branch_offset_id_ex),
        .supposed_next_address_id_ex  (supposed_next_address_id_ex),
        .next_instruction_20_16_id_ex (next_instruction_20_16_id_ex),
        .next_instruction_15_11_id_ex (next_instruction_15_11_id_ex),
        .ctrl_aluOp_id_ex             (ctrl_aluOp_id_ex),
        .ctrl_aluSrc_id_ex            (ctrl_aluSrc_id_ex),
        .ctrl_regDest_id_ex           (ctrl_regDest_id_ex),
        .ctrl_memRead_id_ex           (ctrl_memRead_id_ex),
        .ctrl_memWrite_id_ex          (ctrl_memWrite_id_ex),
        .ctrl_memToReg_id_ex          (ctrl_memToReg_id_ex),
        .ctrl_regWrite_id_ex          (ctrl_regWrite_id_ex),
        .ctrl_branch_id_ex            (ctrl_branch_id_ex),
        .illegal_opcode_id_ex         (illegal_opcode_id_ex)
    );

    typedef struct {
        logic [31:0] rd1, rd2, ext, pc4;
        logic [4:0]  rt, rd;
        logic [1:0]  aluOp;
        logic        aluSrc, regDest, memRead, memWrite, memToReg, regWrite, branch, illegal;
        logic        hazard;
    } exp_t;

    exp_t        expQ[$];
    exp_t        mOut;
    logic [31:0] mRegs[32];
    logic        mHold;
    int          testsRun = 0;
    int          testsFailed = 0;

    function automatic logic [31:0] modelRead(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (ctrl_regWrite_wb && write_register_wb == idx) return write_data_wb;
        return mRegs[idx];
    endfunction

    function automatic logic modelHazard(input logic [31:0] instr);
        return mOut.memRead && mOut.rt != 5'd0 && (mOut.rt == instr[25:21] || mOut.rt == instr[20:16]);
    endfunction

    // Fills the control fields of o from the opcode table, or marks it illegal.
    function automatic exp_t modelDecode(input exp_t o, input logic [5:0] op);
        exp_t r = o;
        {r.aluOp, r.aluSrc, r.regDest, r.memRead, r.memWrite, r.memToReg, r.regWrite, r.branch, r.illegal} = '0;
        if (op == 6'h00) begin r.regDest = 1; r.aluOp = 2'b10; r.regWrite = 1; end
        else if (op == 6'h23) begin r.aluSrc = 1; r.memRead = 1; r.memToReg = 1; r.regWrite = 1; end
        else if (op == 6'h2B) begin r.aluSrc = 1; r.memWrite = 1; end
        else if (op == 6'h04) begin r.branch = 1; r.aluOp = 2'b01; end
        else if (op == 6'h08) begin r.aluSrc = 1; r.regWrite = 1; end
        else r.illegal = 1;
        return r;
    endfunction

    task automatic applyStimulus(input logic rst, input logic fl, input logic we,
                                 input logic [4:0] wr, input logic [31:0] wd, input logic [31:0] instr);
        exp_t e;
        exp_t n;
        logic hz;
        @(posedge clk);
        #1;
        reset              = rst;
        flush              = fl;
        ctrl_regWrite_wb   = we;
        write_register_wb  = wr;
        write_data_wb      = wd;
        instruction_if_id  = instr;
        next_address_if_id = $urandom;
        hz       = modelHazard(instr);
        e        = mOut;
        e.hazard = hz;
        expQ.push_back(e);
        if (!rst) begin
            mOut = '{default: '0};
            for (int i = 0; i < 32; i++) mRegs[i] = 32'd0;
            mHold = 1'b0;
        end else begin
            n     = '{default: '0};
            n.rd1 = modelRead(instr[25:21]);
            n.rd2 = modelRead(instr[20:16]);
            n.ext = 32'($signed(instr[15:0]));
            n.pc4 = next_address_if_id;
            n.rt  = instr[20:16];
            n.rd  = instr[15:11];
            if (!fl && !hz) n = modelDecode(n, instr[31:26]);
            mOut  = n;
            if (we && wr != 5'd0) mRegs[wr] = wd;
            mHold = hz && !fl;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] randInstr();
        logic [5:0] op;
        int kind = $urandom_range(0, 5);
        case (kind)
            0: op = 6'h00;
            1: op = 6'h23;
            2: op = 6'h2B;
            3: op = 6'h04;
            4: op = 6'h08;
            default: begin
                op = 6'($urandom);
                if (op == 6'h00 || op == 6'h23 || op == 6'h2B || op == 6'h04 || op == 6'h08) op = 6'h3F;
            end
        endcase
        return {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
    endfunction

    // Monitor: every cycle the DUT presents an ID/EX word and a stall flag.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("read_data_1", read_data_1_id_ex, e.rd1);
                checkOutput("read_data_2", read_data_2_id_ex, e.rd2);
                checkOutput("ext_offset", extended_branch_offset_id_ex, e.ext);
                checkOutput("next_address", supposed_next_address_id_ex, e.pc4);
                checkOutput("rt", 32'(next_instruction_20_16_id_ex), 32'(e.rt));
                checkOutput("rd", 32'(next_instruction_15_11_id_ex), 32'(e.rd));
                checkOutput("aluOp", 32'(ctrl_aluOp_id_ex), 32'(e.aluOp));
                checkOutput("controls",
                    32'({ctrl_aluSrc_id_ex, ctrl_regDest_id_ex, ctrl_memRead_id_ex, ctrl_memWrite_id_ex,
                         ctrl_memToReg_id_ex, ctrl_regWrite_id_ex, ctrl_branch_id_ex}),
                    32'({e.aluSrc, e.regDest, e.memRead, e.memWrite, e.memToReg, e.regWrite, e.branch}));
                checkOutput("illegal_opcode", 32'(illegal_opcode_id_ex), 32'(e.illegal));
                checkOutput("hazard_stall", 32'(hazard_stall), 32'(e.hazard));
            end
        end
    end

    initial begin
        logic [31:0] instr;
        reset = 1'b0; flush = 1'b0; ctrl_regWrite_wb = 1'b0; write_register_wb = '0;
        write_data_wb = '0; instruction_if_id = '0; next_address_if_id = '0;
        mOut = '{default: '0}; mHold = 1'b0;
        for (int i = 0; i < 32; i++) mRegs[i] = 32'd0;

        applyStimulus(0, 0, 1, 5'd9, 32'h55, 32'h00A01820);
        applyStimulus(0, 0, 0, 5'd0, 32'h0, 32'h0);
        // Writeback then R-type read, then bypassed store, then $0 protection.
        applyStimulus(1, 0, 1, 5'd5, 32'h0000_00AA, 32'h0);
        applyStimulus(1, 0, 0, 5'd0, 32'h0, 32'h00A01820);
        applyStimulus(1, 0, 1, 5'd7, 32'h1234, 32'hAC07FFFC);
        applyStimulus(1, 0, 1, 5'd0, 32'hDEAD, 32'h0);
        applyStimulus(1, 0, 0, 5'd0, 32'h0, 32'h00000820);
        // Load-use: lw $2,0($1); add $4,$2,$3 held for the stall cycle.
        applyStimulus(1, 0, 0, 5'd0, 32'h0, 32'h8C220000);
        applyStimulus(1, 0, 0, 5'd0, 32'h0, 32'h00432020);
        applyStimulus(1, 0, 0, 5'd0, 32'h0, 32'h00432020);
        // Flush of beq, then the beq issues; then flush coinciding with a hazard.
        applyStimulus(1, 1, 0, 5'd0, 32'h0, 32'h10220003);
        applyStimulus(1, 0, 0, 5'd0, 32'h0, 32'h10220003);
        applyStimulus(1, 0, 0, 5'd0, 32'h0, 32'h8C220000);
        applyStimulus(1, 1, 0, 5'd0, 32'h0, 32'h00432020);
        applyStimulus(1, 0, 0, 5'd0, 32'h0, 32'hFC000000);
        applyStimulus(0, 0, 1, 5'd3, 32'h77, 32'h8C220000);
        applyStimulus(1, 0, 0, 5'd0, 32'h0, 32'h00632020);

        for (int c = 0; c < 500; c++) begin
            if (!mHold) instr = randInstr();
            applyStimulus(($urandom_range(0, 49) != 0), ($urandom_range(0, 7) == 0),
                          ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom, instr);
        end
        applyStimulus(1, 0, 0, 5'd0, 32'h0, 32'h0);

        for (int i = 0; i < 20 && expQ.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        #1;
        if (expQ.size() > 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
